// File: rtl/proc_dpath_iter_alu.sv
`default_nettype none
// ============================================================================
//  Module   : proc_dpath_iter_alu
//  Purpose  : Latency-insensitive datapath ALU. Single-cycle integer ops are
//             answered one cycle after acceptance. MUL/MULHU run an iterative
//             shift-add loop that stops early once the remaining multiplier
//             bits are all zero. Request/response use val/rdy handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module proc_dpath_iter_alu #(
  parameter int NBITS   = 32,
  parameter int SHAMT_W = $clog2(NBITS)
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active low
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [3:0]       req_fn,
  input  logic [NBITS-1:0] req_in0,
  input  logic [NBITS-1:0] req_in1,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_out,
  output logic             resp_eq,
  output logic             resp_lt,
  output logic             resp_ltu
);

  localparam int CNT_W = $clog2(NBITS) + 1;

  localparam logic [3:0] FN_ADD   = 4'd0;
  localparam logic [3:0] FN_SUB   = 4'd1;
  localparam logic [3:0] FN_AND   = 4'd2;
  localparam logic [3:0] FN_OR    = 4'd3;
  localparam logic [3:0] FN_XOR   = 4'd4;
  localparam logic [3:0] FN_SLT   = 4'd5;
  localparam logic [3:0] FN_SLTU  = 4'd6;
  localparam logic [3:0] FN_SRA   = 4'd7;
  localparam logic [3:0] FN_SRL   = 4'd8;
  localparam logic [3:0] FN_SLL   = 4'd9;
  localparam logic [3:0] FN_CP0   = 4'd11;
  localparam logic [3:0] FN_CP1   = 4'd12;
  localparam logic [3:0] FN_MUL   = 4'd13;
  localparam logic [3:0] FN_MULHU = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [2*NBITS-1:0]   a_q, a_d;
  logic [NBITS-1:0]     b_q, b_d;
  logic [2*NBITS-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hi_q, hi_d;     // 1: return upper product word
  logic [NBITS-1:0]     result_q, result_d;
  logic                 eq_q, eq_d;
  logic                 lt_q, lt_d;
  logic                 ltu_q, ltu_d;

  logic [SHAMT_W-1:0]   shamt;
  logic                 cmp_eq, cmp_lt, cmp_ltu;
  logic [NBITS-1:0]     alu_res;
  logic                 is_mul;

  logic [2*NBITS-1:0]   acc_step;
  logic [NBITS-1:0]     b_shift;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 calc_last;

  // Comparison flags and single-cycle result from the live request operands
  always_comb begin
    shamt   = req_in1[SHAMT_W-1:0];
    cmp_eq  = (req_in0 == req_in1);
    cmp_lt  = ($signed(req_in0) < $signed(req_in1));
    cmp_ltu = (req_in0 < req_in1);
    is_mul  = (req_fn == FN_MUL) || (req_fn == FN_MULHU);
    alu_res = '0;
    case (req_fn)
      FN_ADD:  alu_res = req_in0 + req_in1;
      FN_SUB:  alu_res = req_in0 - req_in1;
      FN_AND:  alu_res = req_in0 & req_in1;
      FN_OR:   alu_res = req_in0 | req_in1;
      FN_XOR:  alu_res = req_in0 ^ req_in1;
      FN_SLT:  alu_res = {{(NBITS-1){1'b0}}, cmp_lt};
      FN_SLTU: alu_res = {{(NBITS-1){1'b0}}, cmp_ltu};
      FN_SRA:  alu_res = $unsigned($signed(req_in0) >>> shamt);
      FN_SRL:  alu_res = req_in0 >> shamt;
      FN_SLL:  alu_res = req_in0 << shamt;
      FN_CP0:  alu_res = req_in0;
      FN_CP1:  alu_res = req_in1;
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step and its termination test
  always_comb begin
    acc_step  = b_q[0] ? (acc_q + a_q) : acc_q;
    b_shift   = b_q >> 1;
    cnt_inc   = cnt_q + 1'b1;
    calc_last = (b_shift == '0) || (cnt_inc == CNT_W'(NBITS));
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    result_d = result_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    // req_rdy is gated by reset so it reads 0 while reset is held
    req_rdy  = (state_q == IDLE) && reset;
    resp_val = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (req_val) begin
          eq_d  = cmp_eq;
          lt_d  = cmp_lt;
          ltu_d = cmp_ltu;
          if (is_mul) begin
            a_d     = {{NBITS{1'b0}}, req_in0};
            b_d     = req_in1;
            acc_d   = '0;
            cnt_d   = '0;
            hi_d    = (req_fn == FN_MULHU);
            state_d = CALC;
          end else begin
            result_d = alu_res;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        a_d   = a_q << 1;
        b_d   = b_shift;
        cnt_d = cnt_inc;
        if (calc_last) begin
          result_d = hi_q ? acc_step[2*NBITS-1:NBITS] : acc_step[NBITS-1:0];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      result_q <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
    end
  end

  assign resp_out = result_q;
  assign resp_eq  = eq_q;
  assign resp_lt  = lt_q;
  assign resp_ltu = ltu_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_dpath_iter_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_dpath_iter_alu
//  Purpose  : Directed vector table plus hand sequences for backpressure and
//             reset during an iterative multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_dpath_iter_alu;

  logic        clk;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [3:0]  req_fn;
  logic [31:0] req_in0;
  logic [31:0] req_in1;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_out;
  logic        resp_eq;
  logic        resp_lt;
  logic        resp_ltu;

  int tests;
  int fails;

  proc_dpath_iter_alu #(.NBITS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_fn   (req_fn),
    .req_in0  (req_in0),
    .req_in1  (req_in1),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_out (resp_out),
    .resp_eq  (resp_eq),
    .resp_lt  (resp_lt),
    .resp_ltu (resp_ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  fn;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] out;
    logic [2:0]  flags;   // {eq, lt, ltu}
    int          lat;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [3:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] o,
                              input logic [2:0] f, input int l);
    vec_t v;
    v.fn = fn; v.in0 = a; v.in1 = b; v.out = o; v.flags = f; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for req_rdy, issue one request, return the response and its cycle
  task automatic run_op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] out, output logic [2:0] flags, output int lat);
    int t;
    @(negedge clk);
    t = 0;
    while (!req_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("req_rdy wait", 64'(t < 100), 64'd1);
    req_val = 1'b1; req_fn = fn; req_in0 = a; req_in1 = b;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    req_in0 = 32'hDEAD_BEEF;
    req_in1 = 32'h1234_5678;
    lat = 1;
    while (!resp_val && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    out   = resp_out;
    flags = {resp_eq, resp_lt, resp_ltu};
  endtask

  initial begin
    logic [31:0] out;
    logic [2:0]  fl;
    int          lat;
    int          spurious;

    tests = 0; fails = 0;
    reset = 1'b0; req_val = 1'b0; req_fn = '0; req_in0 = '0; req_in1 = '0;
    resp_rdy = 1'b1;

    vecs[0]  = mk(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b010, 1);
    vecs[1]  = mk(4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 3'b011, 1);
    vecs[2]  = mk(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b011, 1);
    vecs[3]  = mk(4'd3,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 3'b000, 1);
    vecs[4]  = mk(4'd4,  32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 3'b010, 1);
    vecs[5]  = mk(4'd5,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 3'b010, 1);
    vecs[6]  = mk(4'd6,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 3'b010, 1);
    vecs[7]  = mk(4'd7,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 3'b010, 1);
    vecs[8]  = mk(4'd8,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 3'b010, 1);
    vecs[9]  = mk(4'd9,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 3'b011, 1);
    vecs[10] = mk(4'd10, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 3'b100, 1);
    vecs[11] = mk(4'd15, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 3'b100, 1);
    vecs[12] = mk(4'd11, 32'h0000_1234, 32'h0000_5678, 32'h0000_1234, 3'b011, 1);
    vecs[13] = mk(4'd12, 32'h0000_1234, 32'h0000_5678, 32'h0000_5678, 3'b011, 1);
    vecs[14] = mk(4'd13, 32'h0000_0007, 32'h0000_0005, 32'h0000_0023, 3'b000, 4);
    vecs[15] = mk(4'd13, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 3'b000, 2);
    vecs[16] = mk(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b100, 33);
    vecs[17] = mk(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 33);
    vecs[18] = mk(4'd13, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 3'b100, 18);
    vecs[19] = mk(4'd14, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 3'b100, 18);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst resp_val", 64'(resp_val), 64'd0);
    chk("rst req_rdy",  64'(req_rdy),  64'd0);
    chk("rst resp_out", 64'(resp_out), 64'd0);
    chk("rst flags",    64'({resp_eq, resp_lt, resp_ltu}), 64'd0);
    reset = 1'b1;
    #1;
    chk("post-rst req_rdy", 64'(req_rdy), 64'd1);

    // Vector table
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].fn, vecs[i].in0, vecs[i].in1, out, fl, lat);
      chk($sformatf("v%0d out", i),   64'(out), 64'(vecs[i].out));
      chk($sformatf("v%0d flags", i), 64'(fl),  64'(vecs[i].flags));
      chk($sformatf("v%0d lat", i),   64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: SUB 3-5 held for 5 cycles with resp_rdy low
    @(negedge clk);
    chk("bp idle rdy", 64'(req_rdy), 64'd1);
    resp_rdy = 1'b0;
    req_val = 1'b1; req_fn = 4'd1; req_in0 = 32'd3; req_in1 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    chk("bp c1 val", 64'(resp_val), 64'd1);
    chk("bp c1 out", 64'(resp_out), 64'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      req_val = 1'b1; req_fn = 4'd0; req_in0 = 32'd7; req_in1 = 32'd9;
      @(negedge clk);
      chk($sformatf("bp h%0d val", i), 64'(resp_val), 64'd1);
      chk($sformatf("bp h%0d out", i), 64'(resp_out), 64'hFFFF_FFFE);
      chk($sformatf("bp h%0d rdy", i), 64'(req_rdy),  64'd0);
    end
    req_val = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("bp after hs rdy", 64'(req_rdy),  64'd1);
    chk("bp after hs val", 64'(resp_val), 64'd0);
    req_val = 1'b1; req_fn = 4'd0; req_in0 = 32'd10; req_in1 = 32'd20;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    chk("bp next val", 64'(resp_val), 64'd1);
    chk("bp next out", 64'(resp_out), 64'd30);

    // Reset during MULHU at cnt=10
    @(negedge clk);
    chk("mr idle rdy", 64'(req_rdy), 64'd1);
    req_val = 1'b1; req_fn = 4'd14; req_in0 = 32'hFFFF_FFFF; req_in1 = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    repeat (10) @(negedge clk);
    chk("mr calc val", 64'(resp_val), 64'd0);
    chk("mr calc rdy", 64'(req_rdy),  64'd0);
    reset = 1'b0;
    #1;
    chk("mr rst val",   64'(resp_val), 64'd0);
    chk("mr rst rdy",   64'(req_rdy),  64'd0);
    chk("mr rst out",   64'(resp_out), 64'd0);
    chk("mr rst flags", 64'({resp_eq, resp_lt, resp_ltu}), 64'd0);
    repeat (2) @(negedge clk);
    chk("mr held rdy", 64'(req_rdy), 64'd0);
    reset = 1'b1;
    #1;
    chk("mr rel rdy", 64'(req_rdy), 64'd1);
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_val) spurious++;
    end
    chk("mr no resp", 64'(spurious), 64'd0);
    run_op(4'd0, 32'd2, 32'd3, out, fl, lat);
    chk("mr add out",   64'(out), 64'd5);
    chk("mr add flags", 64'(fl),  64'(3'b011));
    chk("mr add lat",   64'(lat), 64'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
